// File: rtl/udp_tx_framer.sv
// UDP/IPv4/Ethernet transmit framer: preamble, 42-byte header, payload, pad, FCS and IFG.
// Optional: define UDP_TX_IPID_INC_EN to increment the IPv4 id after each completed frame.
module udp_tx_framer #(
  parameter int unsigned IFG_BYTES   = 12,
  parameter logic [7:0]  IP_TTL      = 8'hC8,
  parameter int unsigned MAX_PAYLOAD = 1472
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] i_src_mac,
  input  logic [47:0] i_dst_mac,
  input  logic [31:0] i_src_ip,
  input  logic [31:0] i_dst_ip,
  input  logic [15:0] i_src_port,
  input  logic [15:0] i_dst_port,
  input  logic [15:0] i_udp_len,
  input  logic        i_start,
  output logic        o_busy,
  input  logic [7:0]  i_pl_data,
  input  logic        i_pl_valid,
  output logic        o_pl_ready,
  output logic        o_tx_en,
  output logic [7:0]  o_tx_data,
  output logic        o_done,
  output logic        o_underrun,
  output logic        o_err
);

  typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, PAD, FCS, IFG} state_t;

  localparam logic [15:0] MAX_LEN  = 16'(MAX_PAYLOAD);
  localparam logic [15:0] LAST_IFG = 16'(IFG_BYTES - 1);
  localparam logic [5:0]  HDR_LAST = 6'd41;

  state_t       r_state, w_next_state;
  logic [15:0]  r_cnt;
  logic [47:0]  r_src_mac, r_dst_mac;
  logic [31:0]  r_src_ip, r_dst_ip;
  logic [15:0]  r_src_port, r_dst_port, r_len, r_ip_csum;
  logic [31:0]  r_crc;
  logic         r_underrun, r_err;

  logic         w_accept, w_last, w_crc_en;
  logic [7:0]   w_byte;
  logic [15:0]  w_ip_len, w_udp_len, w_ip_id;
  logic [41:0][7:0] w_hdr;
  logic [5:0]   w_hdr_idx;
  logic [3:0][7:0]  w_fcs;
  logic [19:0]  w_csum_sum;
  logic [16:0]  w_csum_f1;
  logic [15:0]  w_csum_fold;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

`ifdef UDP_TX_IPID_INC_EN
  logic [15:0] r_ip_id;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_ip_id <= 16'h0000;
    else if (o_done) r_ip_id <= r_ip_id + 16'd1;
  end
  assign w_ip_id = r_ip_id;
`else
  assign w_ip_id = 16'h0000;
`endif

  assign w_accept  = (r_state == IDLE) && i_start && (i_udp_len <= MAX_LEN);
  assign w_ip_len  = r_len + 16'd28;
  assign w_udp_len = r_len + 16'd8;

  // Ten header words with the checksum word as zero, folded twice for end-around carry.
  assign w_csum_sum  = 20'h04500 + {4'h0, w_ip_len} + {4'h0, w_ip_id} + {4'h0, IP_TTL, 8'd17}
                     + {4'h0, r_src_ip[31:16]} + {4'h0, r_src_ip[15:0]}
                     + {4'h0, r_dst_ip[31:16]} + {4'h0, r_dst_ip[15:0]};
  assign w_csum_f1   = {1'b0, w_csum_sum[15:0]} + {13'h0, w_csum_sum[19:16]};
  assign w_csum_fold = w_csum_f1[15:0] + {15'h0, w_csum_f1[16]};

  assign w_hdr = {r_dst_mac, r_src_mac, 16'h0800, 8'h45, 8'h00, w_ip_len, w_ip_id, 16'h0000,
                  IP_TTL, 8'd17, r_ip_csum, r_src_ip, r_dst_ip, r_src_port, r_dst_port,
                  w_udp_len, 16'h0000};
  assign w_hdr_idx = HDR_LAST - r_cnt[5:0];
  assign w_fcs     = ~r_crc;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_src_mac  <= '0;
      r_dst_mac  <= '0;
      r_src_ip   <= '0;
      r_dst_ip   <= '0;
      r_src_port <= '0;
      r_dst_port <= '0;
      r_len      <= '0;
      r_ip_csum  <= '0;
      r_crc      <= 32'hFFFFFFFF;
      r_underrun <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= (r_state == IDLE) && i_start && (i_udp_len > MAX_LEN);
      if (w_accept) begin
        r_src_mac  <= i_src_mac;
        r_dst_mac  <= i_dst_mac;
        r_src_ip   <= i_src_ip;
        r_dst_ip   <= i_dst_ip;
        r_src_port <= i_src_port;
        r_dst_port <= i_dst_port;
        r_len      <= i_udp_len;
        r_crc      <= 32'hFFFFFFFF;
        r_underrun <= 1'b0;
      end
      if (w_crc_en) r_crc <= crc32_byte(r_crc, w_byte);
      if (r_state == PAYLOAD && !i_pl_valid) r_underrun <= 1'b1;
      if (r_state == PREAMBLE) r_ip_csum <= ~w_csum_fold;
      if (w_last || r_state == IDLE) r_cnt <= '0;
      else                           r_cnt <= r_cnt + 16'd1;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_last       = 1'b0;
    w_crc_en     = 1'b0;
    w_byte       = 8'h00;
    o_tx_en      = 1'b0;
    o_pl_ready   = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      IDLE: if (w_accept) w_next_state = PREAMBLE;
      PREAMBLE: begin
        o_tx_en = 1'b1;
        w_byte  = (r_cnt == 16'd7) ? 8'hD5 : 8'h55;
        if (r_cnt == 16'd7) begin
          w_last       = 1'b1;
          w_next_state = HEADER;
        end
      end
      HEADER: begin
        o_tx_en  = 1'b1;
        w_crc_en = 1'b1;
        w_byte   = w_hdr[w_hdr_idx];
        if (r_cnt == 16'd41) begin
          w_last       = 1'b1;
          w_next_state = (r_len != 16'd0) ? PAYLOAD : PAD;
        end
      end
      PAYLOAD: begin
        o_tx_en    = 1'b1;
        o_pl_ready = 1'b1;
        w_crc_en   = 1'b1;
        w_byte     = i_pl_valid ? i_pl_data : 8'h00;
        if (r_cnt == r_len - 16'd1) begin
          w_last       = 1'b1;
          w_next_state = (r_len < 16'd18) ? PAD : FCS;
        end
      end
      PAD: begin
        o_tx_en  = 1'b1;
        w_crc_en = 1'b1;
        if (r_cnt == 16'd17 - r_len) begin
          w_last       = 1'b1;
          w_next_state = FCS;
        end
      end
      FCS: begin
        o_tx_en = 1'b1;
        w_byte  = w_fcs[r_cnt[1:0]];
        if (r_cnt == 16'd3) begin
          w_last       = 1'b1;
          o_done       = 1'b1;
          w_next_state = (IFG_BYTES == 0) ? IDLE : IFG;
        end
      end
      IFG: begin
        if (r_cnt == LAST_IFG) begin
          w_last       = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign o_tx_data  = w_byte;
  assign o_busy     = (r_state != IDLE);
  assign o_underrun = o_done & r_underrun;
  assign o_err      = r_err;

endmodule

// File: doc/udp_tx_framer.md
UDP_TX_FRAMER -- requirements
Module: udp_tx_framer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- IFG_BYTES, 12, idle cycles after FCS.
- IP_TTL, 8'hC8, IPv4 TTL.
- MAX_PAYLOAD, 1472, largest accepted UDP payload in bytes.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- i_src_mac / i_dst_mac, in, 48, MAC addresses.
- i_src_ip / i_dst_ip, in, 32, IPv4 addresses.
- i_src_port / i_dst_port, in, 16, UDP ports.
- i_udp_len, in, 16, UDP payload byte count.
- i_start, in, 1, frame request.
- o_busy, out, 1, frame in progress.
- i_pl_data, in, 8, payload byte.
- i_pl_valid, in, 1, payload byte valid.
- o_pl_ready, out, 1, payload byte taken.
- o_tx_en, out, 1, MII-style byte strobe.
- o_tx_data, out, 8, transmit byte.
- o_done, out, 1, one-cycle end-of-frame pulse.
- o_underrun, out, 1, valid with o_done: payload starved.
- o_err, out, 1, one-cycle pulse: request rejected.

Function
REQ-004 The FSM SHALL use states IDLE, PREAMBLE, HEADER, PAYLOAD, PAD, FCS and IFG.
REQ-005 In IDLE, i_start=1 with i_udp_len<=MAX_PAYLOAD SHALL capture all header inputs and enter PREAMBLE; o_tx_en=1 on the next cycle.
REQ-006 In IDLE, i_start=1 with i_udp_len>MAX_PAYLOAD SHALL pulse o_err for 1 cycle, stay in IDLE and transmit nothing.
REQ-007 i_start while o_busy=1 SHALL be ignored (no capture, no o_err).
REQ-008 PREAMBLE SHALL emit 7 bytes of 0x55 then 0xD5.
REQ-009 HEADER SHALL emit 42 bytes, MSB byte first per field, in this order:
- dst MAC, src MAC, type 0x0800.
- IPv4: 0x45, 0x00, total length = 28+len, id, flags/offset 0x0000, IP_TTL, protocol 17, checksum, src IP, dst IP.
- UDP: src port, dst port, length = 8+len, checksum 0x0000.
REQ-010 The IP checksum SHALL be the ones'-complement of the end-around-carry sum of the ten header 16-bit words (checksum word taken as 0); it SHALL be computed during PREAMBLE and valid before HEADER byte 24.
REQ-011 PAYLOAD SHALL last exactly len cycles, with o_pl_ready=1 on each cycle. If i_pl_valid=1 the byte is i_pl_data; otherwise 0x00 is sent and the underrun flag is set. o_tx_en SHALL never drop mid-frame.
REQ-012 If len<18, PAD SHALL emit 18-len bytes of 0x00 so the frame before FCS is 60 bytes.
REQ-013 FCS SHALL be CRC-32 (reflected polynomial 0x04C11DB7, init 0xFFFFFFFF, final inversion) over dst MAC through PAD, sent as 4 bytes, least-significant byte first.
REQ-014 On the last FCS byte, o_done SHALL pulse and o_underrun SHALL show the flag; IFG then holds o_tx_en=0 for IFG_BYTES cycles; o_busy SHALL fall when returning to IDLE.
REQ-015 o_tx_data SHALL be 0x00 whenever o_tx_en=0; o_pl_ready SHALL be 0 outside PAYLOAD.

Reset
REQ-016 rst_n=0 SHALL immediately force IDLE, with o_tx_en, o_busy, o_pl_ready, o_done, o_underrun and o_err all 0, o_tx_data=0x00, CRC register=0xFFFFFFFF and IP id=0; reset mid-frame SHALL truncate the frame with no o_done.

Configuration
REQ-017 With UDP_TX_IPID_INC_EN defined, the IP id SHALL be 0x0000 for the first frame after reset and increment by 1 (wrapping 0xFFFF->0x0000) after each completed frame; without it, the id SHALL always be 0x0000.

Verification
REQ-018 len=0 -> o_tx_en high 72 consecutive cycles (8+42+18+4), UDP length 0x0008, o_done on the 72nd cycle, o_busy low 12 cycles later.
REQ-019 src 10.0.0.100, dst 10.0.0.2, len=1024, id 0 -> total length 0x041C, IP checksum 0xDA6B.
REQ-020 Any frame -> CRC-32 over dst MAC..FCS yields residue 0xC704DD7B, and the frame matches the reference model byte for byte.
REQ-021 len=1473 -> o_err pulse, o_tx_en stays 0; a later len=1472 request is accepted.
REQ-022 len=4 with i_pl_valid low on the 2nd byte -> 0x00 sent there, 14 pad bytes, o_underrun=1 with o_done.
REQ-023 Two frames with UDP_TX_IPID_INC_EN defined -> ids 0x0000, 0x0001; without it -> 0x0000, 0x0000; i_start during frame 1 ignored.
